// File: rtl/zelda_pkg.sv
// Shared types and constants for the sprite motion controller.
package zelda_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WALK    = 2'd1,
    BLOCKED = 2'd2
  } motion_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [7:0] keycode);
    key_dec_t kd;
    kd.valid = 1'b1;
    kd.dir   = DOWN;
    case (keycode)
      KEY_W:   kd.dir = UP;
      KEY_S:   kd.dir = DOWN;
      KEY_A:   kd.dir = LEFT;
      KEY_D:   kd.dir = RIGHT;
      default: kd.valid = 1'b0;
    endcase
    return kd;
  endfunction

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Bundle between the vga/input side and the sprite motion controller.
interface sprite_motion_ctrl_if;
  import zelda_pkg::*;

  logic       vs;
  logic [7:0] keycode;
  logic       collision;
  logic [9:0] spriteX;
  logic [9:0] spriteY;
  logic [9:0] sprite_size;
  dir_t       facing;
  logic       anim_frame;
  logic       walking;
  logic       frame_tick;

  modport master (
    output vs, keycode, collision,
    input  spriteX, spriteY, sprite_size, facing, anim_frame, walking, frame_tick
  );

  modport slave (
    input  vs, keycode, collision,
    output spriteX, spriteY, sprite_size, facing, anim_frame, walking, frame_tick
  );

endinterface

// File: rtl/sprite_motion_ctrl_vs_edge_detect.sv
// Registers vsync and produces a combinational rising-edge tick plus a registered copy.
module vs_edge_detect (
  input  logic vga_clk,
  input  logic Reset,
  input  logic vs,
  output logic tick,
  output logic frame_tick
);

  logic vs_q;
  logic frame_tick_q;

  assign tick       = vs & ~vs_q;
  assign frame_tick = frame_tick_q;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      vs_q         <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_q         <= vs;
      frame_tick_q <= tick;
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position/animation controller with rollback to the last
// collision-free position.
module sprite_motion_ctrl
  import zelda_pkg::*;
#(
  parameter logic [9:0]  START_X     = 10'd304,
  parameter logic [9:0]  START_Y     = 10'd224,
  parameter logic [9:0]  STEP        = 10'd2,
  parameter logic [9:0]  SPRITE_SIZE = 10'd32,
  parameter int unsigned ANIM_DIV    = 8
) (
  input logic                 vga_clk,
  input logic                 Reset,
  sprite_motion_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ANIM_DIV - 1);
  localparam logic [10:0]     MaxX    = 11'(SCREEN_W) - {1'b0, SPRITE_SIZE};
  localparam logic [10:0]     MaxY    = 11'(SCREEN_H) - {1'b0, SPRITE_SIZE};

  logic tick;
  logic frame_tick;

  vs_edge_detect u_vs_edge (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .vs         (bus.vs),
    .tick       (tick),
    .frame_tick (frame_tick)
  );

  motion_state_t   state_q;
  logic [9:0]      pos_x_q, pos_y_q;
  logic [9:0]      safe_x_q, safe_y_q;
  dir_t            facing_q, blocked_dir_q;
  logic            anim_frame_q;
  logic [CntW-1:0] anim_cnt_q;
  logic            walking_q;
  logic            coll_seen_q;

  key_dec_t    kd;
  logic [10:0] x_ext, y_ext, step_ext;
  logic [10:0] x_dec, x_inc, y_dec, y_inc;
  logic [9:0]  move_x, move_y;
  logic        coll_hit;

  // 11-bit arithmetic so the clamp compares never wrap.
  always_comb begin
    kd       = decode_key(bus.keycode);
    x_ext    = {1'b0, pos_x_q};
    y_ext    = {1'b0, pos_y_q};
    step_ext = {1'b0, STEP};
    x_dec    = (x_ext < step_ext) ? 11'd0 : x_ext - step_ext;
    x_inc    = (x_ext + step_ext > MaxX) ? MaxX : x_ext + step_ext;
    y_dec    = (y_ext < step_ext) ? 11'd0 : y_ext - step_ext;
    y_inc    = (y_ext + step_ext > MaxY) ? MaxY : y_ext + step_ext;
    move_x   = pos_x_q;
    move_y   = pos_y_q;
    case (kd.dir)
      UP:    move_y = 10'(y_dec);
      DOWN:  move_y = 10'(y_inc);
      LEFT:  move_x = 10'(x_dec);
      RIGHT: move_x = 10'(x_inc);
    endcase
    coll_hit = coll_seen_q | bus.collision;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      pos_x_q       <= START_X;
      pos_y_q       <= START_Y;
      safe_x_q      <= START_X;
      safe_y_q      <= START_Y;
      facing_q      <= DOWN;
      blocked_dir_q <= DOWN;
      anim_frame_q  <= 1'b0;
      anim_cnt_q    <= '0;
      walking_q     <= 1'b0;
      coll_seen_q   <= 1'b0;
    end else begin
      // A collision on the tick cycle is consumed by that tick via coll_hit.
      if (tick) begin
        coll_seen_q <= 1'b0;
      end else if (bus.collision) begin
        coll_seen_q <= 1'b1;
      end
      if (tick) begin
        if (coll_hit) begin
          pos_x_q       <= safe_x_q;
          pos_y_q       <= safe_y_q;
          state_q       <= BLOCKED;
          blocked_dir_q <= facing_q;
          walking_q     <= 1'b0;
        end else begin
          safe_x_q <= pos_x_q;
          safe_y_q <= pos_y_q;
          if (!kd.valid) begin
            state_q      <= IDLE;
            walking_q    <= 1'b0;
            anim_frame_q <= 1'b0;
            anim_cnt_q   <= '0;
          end else if (state_q == BLOCKED && kd.dir == blocked_dir_q) begin
            state_q   <= BLOCKED;
            walking_q <= 1'b0;
          end else begin
            state_q   <= WALK;
            walking_q <= 1'b1;
            facing_q  <= kd.dir;
            pos_x_q   <= move_x;
            pos_y_q   <= move_y;
            if (anim_cnt_q == CntLast) begin
              anim_frame_q <= ~anim_frame_q;
              anim_cnt_q   <= '0;
            end else begin
              anim_cnt_q <= anim_cnt_q + CntW'(1);
            end
          end
        end
      end
    end
  end

  assign bus.spriteX     = pos_x_q;
  assign bus.spriteY     = pos_y_q;
  assign bus.sprite_size = SPRITE_SIZE;
  assign bus.facing      = facing_q;
  assign bus.anim_frame  = anim_frame_q;
  assign bus.walking     = walking_q;
  assign bus.frame_tick  = frame_tick;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl; a second instance starts near the origin.
module tb_sprite_motion_ctrl;
  import zelda_pkg::*;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vs = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       collision = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  sprite_motion_ctrl_if ifc ();
  sprite_motion_ctrl_if ifc_aux ();

  assign ifc.vs            = vs;
  assign ifc.keycode       = keycode;
  assign ifc.collision     = collision;
  assign ifc_aux.vs        = vs;
  assign ifc_aux.keycode   = keycode;
  assign ifc_aux.collision = collision;

  always #5 vga_clk = ~vga_clk;

  sprite_motion_ctrl u_dut (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .bus     (ifc)
  );

  sprite_motion_ctrl #(
    .START_X (10'd1),
    .START_Y (10'd1)
  ) u_aux (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .bus     (ifc_aux)
  );

  task automatic apply_reset();
    @(negedge vga_clk);
    Reset = 1'b1; vs = 1'b0; keycode = 8'h00; collision = 1'b0;
    @(negedge vga_clk);
    Reset = 1'b0;
  endtask

  // Returns one cycle after the tick edge; vs stays high so a level-sensitive
  // tick would fire again.
  task automatic do_tick(input logic [7:0] key, input logic coll_on_tick);
    @(negedge vga_clk);
    vs = 1'b0; keycode = key;
    @(negedge vga_clk);
    vs = 1'b1; collision = coll_on_tick;
    @(negedge vga_clk);
    collision = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors += 8;
    if (ifc.spriteX !== 10'd304) begin miscompares++;
      $display("FAIL reset_x: got %0d want 304", ifc.spriteX); end
    if (ifc.spriteY !== 10'd224) begin miscompares++;
      $display("FAIL reset_y: got %0d want 224", ifc.spriteY); end
    if (ifc.facing !== DOWN) begin miscompares++;
      $display("FAIL reset_facing: got %0d want %0d", ifc.facing, DOWN); end
    if (ifc.anim_frame !== 1'b0) begin miscompares++;
      $display("FAIL reset_anim: got %b want 0", ifc.anim_frame); end
    if (ifc.walking !== 1'b0) begin miscompares++;
      $display("FAIL reset_walking: got %b want 0", ifc.walking); end
    if (ifc.frame_tick !== 1'b0) begin miscompares++;
      $display("FAIL reset_frame_tick: got %b want 0", ifc.frame_tick); end
    if (ifc.sprite_size !== 10'd32) begin miscompares++;
      $display("FAIL sprite_size: got %0d want 32", ifc.sprite_size); end
    if (ifc_aux.spriteX !== 10'd1) begin miscompares++;
      $display("FAIL aux_reset_x: got %0d want 1", ifc_aux.spriteX); end
    do_tick(KEY_D, 1'b0);
    do_tick(KEY_D, 1'b0);
    vectors++;
    if (ifc.spriteX !== 10'd308 || ifc.walking !== 1'b1) begin miscompares++;
      $display("FAIL prewalk: got x=%0d walk=%b want x=308 walk=1", ifc.spriteX, ifc.walking);
    end
    apply_reset();
    vectors += 5;
    if (ifc.spriteX !== 10'd304) begin miscompares++;
      $display("FAIL midreset_x: got %0d want 304", ifc.spriteX); end
    if (ifc.spriteY !== 10'd224) begin miscompares++;
      $display("FAIL midreset_y: got %0d want 224", ifc.spriteY); end
    if (ifc.facing !== DOWN) begin miscompares++;
      $display("FAIL midreset_facing: got %0d want %0d", ifc.facing, DOWN); end
    if (ifc.walking !== 1'b0 || ifc.anim_frame !== 1'b0) begin miscompares++;
      $display("FAIL midreset_walk_anim: got %b%b want 00", ifc.walking, ifc.anim_frame); end
    if (ifc.frame_tick !== 1'b0) begin miscompares++;
      $display("FAIL midreset_frame_tick: got %b want 0", ifc.frame_tick); end
  endtask

  task automatic test_walk_right();
    for (int i = 1; i <= 3; i++) begin
      logic [9:0] exp_x;
      exp_x = 10'(304 + 2 * i);
      do_tick(KEY_D, 1'b0);
      vectors += 4;
      if (ifc.spriteX !== exp_x || ifc.spriteY !== 10'd224) begin miscompares++;
        $display("FAIL walk_pos[%0d]: got (%0d,%0d) want (%0d,224)", i, ifc.spriteX,
                 ifc.spriteY, exp_x); end
      if (ifc.facing !== RIGHT) begin miscompares++;
        $display("FAIL walk_facing[%0d]: got %0d want %0d", i, ifc.facing, RIGHT); end
      if (ifc.walking !== 1'b1) begin miscompares++;
        $display("FAIL walk_walking[%0d]: got %b want 1", i, ifc.walking); end
      if (ifc.frame_tick !== 1'b1) begin miscompares++;
        $display("FAIL walk_frame_tick[%0d]: got %b want 1", i, ifc.frame_tick); end
    end
    repeat (3) @(negedge vga_clk);
    vectors += 2;
    if (ifc.spriteX !== 10'd310) begin miscompares++;
      $display("FAIL walk_hold: got %0d want 310", ifc.spriteX); end
    if (ifc.frame_tick !== 1'b0) begin miscompares++;
      $display("FAIL frame_tick_pulse: got %b want 0", ifc.frame_tick); end
  endtask

  task automatic test_collision_mid();
    @(negedge vga_clk); collision = 1'b1;
    @(negedge vga_clk); collision = 1'b0;
    vectors++;
    if (ifc.spriteX !== 10'd310 || ifc.walking !== 1'b1) begin miscompares++;
      $display("FAIL coll_pre_tick: got x=%0d walk=%b want x=310 walk=1", ifc.spriteX,
               ifc.walking); end
    do_tick(KEY_D, 1'b0);
    vectors += 2;
    if (ifc.spriteX !== 10'd308) begin miscompares++;
      $display("FAIL coll_rollback: got %0d want 308", ifc.spriteX); end
    if (ifc.walking !== 1'b0 || ifc.facing !== RIGHT) begin miscompares++;
      $display("FAIL coll_blocked: got walk=%b facing=%0d want walk=0 facing=%0d",
               ifc.walking, ifc.facing, RIGHT); end
    for (int i = 0; i < 2; i++) begin
      do_tick(KEY_D, 1'b0);
      vectors++;
      if (ifc.spriteX !== 10'd308 || ifc.walking !== 1'b0) begin miscompares++;
        $display("FAIL blocked_hold[%0d]: got x=%0d walk=%b want x=308 walk=0", i,
                 ifc.spriteX, ifc.walking); end
    end
    do_tick(KEY_S, 1'b0);
    vectors += 2;
    if (ifc.spriteX !== 10'd308 || ifc.spriteY !== 10'd226) begin miscompares++;
      $display("FAIL blocked_escape: got (%0d,%0d) want (308,226)", ifc.spriteX, ifc.spriteY);
    end
    if (ifc.walking !== 1'b1 || ifc.facing !== DOWN) begin miscompares++;
      $display("FAIL blocked_escape_state: got walk=%b facing=%0d want walk=1 facing=%0d",
               ifc.walking, ifc.facing, DOWN); end
  endtask

  task automatic test_anim();
    do_tick(8'h00, 1'b0);
    vectors++;
    if (ifc.walking !== 1'b0 || ifc.anim_frame !== 1'b0) begin miscompares++;
      $display("FAIL anim_idle: got walk=%b anim=%b want 0 0", ifc.walking, ifc.anim_frame);
    end
    for (int i = 1; i <= 24; i++) begin
      logic exp_anim;
      exp_anim = ((i >= 8) && (i < 16)) || (i == 24);
      do_tick(KEY_W, 1'b0);
      vectors++;
      if (ifc.anim_frame !== exp_anim) begin miscompares++;
        $display("FAIL anim_frame[%0d]: got %b want %b", i, ifc.anim_frame, exp_anim); end
    end
    vectors++;
    if (ifc.spriteY !== 10'd178 || ifc.facing !== UP) begin miscompares++;
      $display("FAIL anim_walk_up: got y=%0d facing=%0d want y=178 facing=%0d", ifc.spriteY,
               ifc.facing, UP); end
    do_tick(8'h00, 1'b0);
    vectors++;
    if (ifc.anim_frame !== 1'b0 || ifc.walking !== 1'b0 || ifc.spriteY !== 10'd178) begin
      miscompares++;
      $display("FAIL anim_release: got anim=%b walk=%b y=%0d want 0 0 178", ifc.anim_frame,
               ifc.walking, ifc.spriteY); end
  endtask

  task automatic test_clamp_high();
    apply_reset();
    repeat (151) do_tick(KEY_D, 1'b0);
    vectors++;
    if (ifc.spriteX !== 10'd606) begin miscompares++;
      $display("FAIL clamp_x_approach: got %0d want 606", ifc.spriteX); end
    do_tick(KEY_D, 1'b0);
    vectors++;
    if (ifc.spriteX !== 10'd608) begin miscompares++;
      $display("FAIL clamp_x_edge: got %0d want 608", ifc.spriteX); end
    do_tick(KEY_D, 1'b0);
    vectors++;
    if (ifc.spriteX !== 10'd608 || ifc.walking !== 1'b1) begin miscompares++;
      $display("FAIL clamp_x_hold: got x=%0d walk=%b want 608 1", ifc.spriteX, ifc.walking);
    end
    repeat (112) do_tick(KEY_S, 1'b0);
    vectors++;
    if (ifc.spriteY !== 10'd448) begin miscompares++;
      $display("FAIL clamp_y_edge: got %0d want 448", ifc.spriteY); end
    do_tick(KEY_S, 1'b0);
    vectors++;
    if (ifc.spriteY !== 10'd448 || ifc.spriteX !== 10'd608) begin miscompares++;
      $display("FAIL clamp_y_hold: got (%0d,%0d) want (608,448)", ifc.spriteX, ifc.spriteY);
    end
  endtask

  task automatic test_clamp_low();
    apply_reset();
    do_tick(KEY_A, 1'b0);
    vectors++;
    if (ifc_aux.spriteX !== 10'd0 || ifc_aux.spriteY !== 10'd1) begin miscompares++;
      $display("FAIL clamp_left: got (%0d,%0d) want (0,1)", ifc_aux.spriteX, ifc_aux.spriteY);
    end
    do_tick(KEY_A, 1'b0);
    vectors++;
    if (ifc_aux.spriteX !== 10'd0) begin miscompares++;
      $display("FAIL clamp_left_hold: got %0d want 0", ifc_aux.spriteX); end
    do_tick(KEY_W, 1'b0);
    vectors++;
    if (ifc_aux.spriteY !== 10'd0) begin miscompares++;
      $display("FAIL clamp_up: got %0d want 0", ifc_aux.spriteY); end
    do_tick(KEY_W, 1'b0);
    vectors++;
    if (ifc_aux.spriteY !== 10'd0 || ifc_aux.walking !== 1'b1 || ifc_aux.facing !== UP) begin
      miscompares++;
      $display("FAIL clamp_up_hold: got y=%0d walk=%b facing=%0d want 0 1 %0d",
               ifc_aux.spriteY, ifc_aux.walking, ifc_aux.facing, UP); end
  endtask

  task automatic test_coll_on_tick();
    apply_reset();
    do_tick(KEY_D, 1'b0);
    vectors++;
    if (ifc.spriteX !== 10'd306) begin miscompares++;
      $display("FAIL tickcoll_pre: got %0d want 306", ifc.spriteX); end
    do_tick(KEY_D, 1'b1);
    vectors++;
    if (ifc.spriteX !== 10'd304 || ifc.walking !== 1'b0) begin miscompares++;
      $display("FAIL tickcoll_rollback: got x=%0d walk=%b want 304 0", ifc.spriteX,
               ifc.walking); end
    do_tick(KEY_S, 1'b0);
    vectors++;
    if (ifc.spriteX !== 10'd304 || ifc.spriteY !== 10'd226 || ifc.walking !== 1'b1) begin
      miscompares++;
      $display("FAIL tickcoll_cleared: got (%0d,%0d) walk=%b want (304,226) 1", ifc.spriteX,
               ifc.spriteY, ifc.walking); end
  endtask

  initial begin
    test_reset();
    test_walk_right();
    test_collision_mid();
    test_anim();
    test_clamp_high();
    test_clamp_low();
    test_coll_on_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
